uart_population_reporter: RTL and testbench
===========================================

Name: uart_population_reporter

Overview:
Parametrised successor to the single-answer UART dump used at the end of a GA run. On a start pulse it snapshots the top NUM_REPORT individuals of the selected population and encodes each one as uppercase ASCII hex, terminated by CR LF. It serialises the result over an integrated 8N1 UART transmitter with a programmable bit period. It sits between the selection stage and the board TX pin, and adds abort, busy and a one-cycle done pulse.

Parameters:
GENE_BITS, 150, bits per individual.
POP_SIZE, 10, individuals in sel_population.
NUM_REPORT, 1, individuals sent per report, 1..POP_SIZE, taken from the MSB end.
CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200).

Ports:
clk  in  1  system clock, all logic on rising edge.
rst_n  in  1  asynchronous active-low reset.
sel_population  in  GENE_BITS*POP_SIZE  population; individual 0 = [GENE_BITS*POP_SIZE-1 -: GENE_BITS].
start  in  1  request a report; sampled only when idle.
abort  in  1  stop the report after the character currently on the line.
tx  out  1  UART serial output, idle high.
busy  out  1  high from accepted start until done.
done  out  1  one-cycle pulse when the report ends (normal or aborted).

Behaviour:
- Reset (async, rst_n low): tx=1, busy=0, done=0, state=IDLE, all counters 0. An in-flight character is truncated and tx goes high immediately.
- Derived constants:
  - HEX_CHARS = ceil(GENE_BITS/4).
  - The individual is zero-extended on the left to 4*HEX_CHARS bits.
  - CHARS_PER_IND = HEX_CHARS+2.
- Encoding:
  - Each nibble is sent MS nibble first.
  - Nibble 0-9 maps to 0x30-0x39; nibble A-F maps to 0x41-0x46.
  - After the last nibble of each individual, send 0x0D then 0x0A.
- Snapshot:
  - On an accepted start, the top NUM_REPORT*GENE_BITS bits are latched into an internal register.
  - Later changes to sel_population do not affect the report in progress.
- FSM states:
  - IDLE: start=1 latches the snapshot, sets busy=1, goes to FETCH.
  - FETCH: one cycle; selects the next byte from the individual, nibble and CR/LF counters into the shift register; goes to START_BIT.
  - START_BIT: tx=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits, LSB first, each CLKS_PER_BIT cycles.
  - STOP_BIT: tx=1 for CLKS_PER_BIT cycles. At its end go to FETCH if bytes remain and abort_pending=0; otherwise go to DONE.
  - DONE: one cycle; done=1, busy=0 on the following edge, then IDLE.
- Abort:
  - abort=1 while busy sets abort_pending.
  - The character in flight always completes, stop bit included, so no framing error appears on the line.
  - abort while idle is ignored; abort_pending clears in DONE.
- Simultaneous events:
  - start while busy is ignored.
  - start and abort together in IDLE: start is accepted and abort ignored.
  - start in the DONE cycle is ignored.
  - start in the first IDLE cycle after DONE is accepted.
- Latency:
  - tx falls 2 cycles after the edge that samples start.
  - Consecutive characters are separated by exactly 1 FETCH cycle of idle-high.
  - Total busy time = NUM_REPORT*CHARS_PER_IND*(10*CLKS_PER_BIT+1)+2 cycles.
  - done goes high the cycle after the last stop bit ends.
- Counters:
  - The bit-period counter holds ceil(log2(CLKS_PER_BIT)) bits and counts 0..CLKS_PER_BIT-1, then wraps.
  - The char counter wraps at CHARS_PER_IND and increments the individual counter.
  - The report ends after individual NUM_REPORT-1.
- CLKS_PER_BIT must be >= 2; NUM_REPORT must be 1..POP_SIZE (compile-time check).

Test Plan:
- Common configuration: GENE_BITS=8, POP_SIZE=4, NUM_REPORT=2, CLKS_PER_BIT=4.
- Normal report:
  - Stimulus: population = A5,3C,00,FF (individual 0 first), pulse start.
  - Required: UART monitor decodes 0x41 0x35 0x0D 0x0A 0x33 0x43 0x0D 0x0A.
  - Required: busy high for 8*41+2=330 cycles; exactly one done pulse.
- Padding: GENE_BITS=6, NUM_REPORT=1, individual 6'b101101 -> bytes 0x32 0x44 0x0D 0x0A ("2D").
- Snapshot isolation:
  - Stimulus: change sel_population to all 0xFF one cycle after start.
  - Required: output still 0x41 0x35 0x0D 0x0A 0x33 0x43 0x0D 0x0A.
- Abort:
  - Stimulus: assert abort in the 3rd data bit of byte 2 (0x35).
  - Required: 0x35 completes with a valid stop bit, no further bytes, done pulses 1 cycle after that stop bit, busy=0.
- Start while busy:
  - Stimulus: pulse start mid-report.
  - Required: ignored; a single 8-byte frame; start one cycle after done returns to IDLE launches a new report.
- Async reset mid-bit:
  - Stimulus: drop rst_n during a data bit = 0.
  - Required: tx=1, busy=0 before the next clk edge.
  - Required: after release, a fresh start produces a clean full frame.

Source files
------------

// File: rtl/uart_population_reporter.sv
`default_nettype none
// ============================================================================
//  Module   : uart_population_reporter
//  Purpose  : On a start pulse, snapshots the top NUM_REPORT individuals of
//             the selected population. Each individual is sent as uppercase
//             ASCII hex (MS nibble first) followed by CR LF, over an
//             integrated 8N1 UART transmitter.
//  Ports    : clk_i            - system clock, rising edge
//             rst_ni           - asynchronous active-low reset
//             sel_population_i - population, individual 0 in the MS bits
//             start_i          - request a report (sampled only when idle)
//             abort_i          - stop after the character on the line
//             tx_o             - UART serial output, idle high
//             busy_o           - high from accepted start until done
//             done_o           - one-cycle pulse when the report ends
//  Revision : 1.0 - initial release
// ============================================================================
module uart_population_reporter #(
   parameter int GENE_BITS    = 150,
   parameter int POP_SIZE     = 10,
   parameter int NUM_REPORT   = 1,
   parameter int CLKS_PER_BIT = 868
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic [GENE_BITS*POP_SIZE-1:0] sel_population_i,
   input  logic                          start_i,
   input  logic                          abort_i,
   output logic                          tx_o,
   output logic                          busy_o,
   output logic                          done_o
);

   localparam int C_HEX_CHARS     = (GENE_BITS + 3) / 4;
   localparam int C_PAD_BITS      = 4 * C_HEX_CHARS;
   localparam int C_CHARS_PER_IND = C_HEX_CHARS + 2;
   localparam int C_SNAP_BITS     = NUM_REPORT * GENE_BITS;
   localparam int C_CNT_W         = $clog2(CLKS_PER_BIT);
   localparam int C_CHAR_W        = $clog2(C_CHARS_PER_IND);
   localparam int C_IND_W         = (NUM_REPORT > 1) ? $clog2(NUM_REPORT) : 1;
   localparam logic [31:0] C_IND_STEP = 32'(GENE_BITS);

   if (CLKS_PER_BIT < 2 || NUM_REPORT < 1 || NUM_REPORT > POP_SIZE) begin : g_param_check
      $error("uart_population_reporter: CLKS_PER_BIT must be >= 2 and NUM_REPORT in 1..POP_SIZE");
   end

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_START = 3'd2,
      S_DATA  = 3'd3,
      S_STOP  = 3'd4,
      S_DONE  = 3'd5
   } state_e;

   state_e                   state_q, state_d;
   logic [C_SNAP_BITS-1:0]   snap_q, snap_d;
   logic [C_CHAR_W-1:0]      char_q, char_d;
   logic [C_IND_W-1:0]       ind_q, ind_d;
   logic                     last_q, last_d;
   logic [7:0]               shift_q, shift_d;
   logic [C_CNT_W-1:0]       cnt_q, cnt_d;
   logic [2:0]               bit_idx_q, bit_idx_d;
   logic                     abort_pend_q, abort_pend_d;
   logic                     tx_q, tx_d;
   logic                     busy_q, busy_d;
   logic                     done_q, done_d;

   logic [C_SNAP_BITS-1:0]   w_snap_shift;
   logic [GENE_BITS-1:0]     w_ind;
   logic [C_PAD_BITS-1:0]    w_ind_pad;
   logic [C_PAD_BITS-1:0]    w_pad_shift;
   logic [3:0]               w_nibble;
   logic [7:0]               w_hex;
   logic [7:0]               w_byte;
   logic                     w_bit_end;
   logic                     w_char_last;
   logic                     w_ind_last;
   logic                     w_unused;

   // Current individual is brought to the top of the snapshot, then the
   // current nibble to the top of the zero-extended individual.
   assign w_snap_shift = snap_q << (C_IND_STEP * 32'(ind_q));
   assign w_ind        = w_snap_shift[C_SNAP_BITS-1 -: GENE_BITS];
   assign w_ind_pad    = C_PAD_BITS'(w_ind);
   assign w_pad_shift  = w_ind_pad << {32'(char_q), 2'b00};
   assign w_nibble     = w_pad_shift[C_PAD_BITS-1 -: 4];
   assign w_hex        = (w_nibble < 4'd10) ? (8'h30 + {4'h0, w_nibble})
                                            : (8'h37 + {4'h0, w_nibble});
   assign w_byte       = (char_q == C_CHAR_W'(C_HEX_CHARS))     ? 8'h0D :
                         (char_q == C_CHAR_W'(C_HEX_CHARS + 1)) ? 8'h0A : w_hex;

   assign w_bit_end   = (cnt_q == C_CNT_W'(CLKS_PER_BIT - 1));
   assign w_char_last = (char_q == C_CHAR_W'(C_CHARS_PER_IND - 1));
   assign w_ind_last  = (ind_q == C_IND_W'(NUM_REPORT - 1));

   // Bits outside the reported window are intentionally never read.
   assign w_unused = ^{sel_population_i, w_snap_shift, w_pad_shift};

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= S_IDLE;
         snap_q       <= '0;
         char_q       <= '0;
         ind_q        <= '0;
         last_q       <= 1'b0;
         shift_q      <= '0;
         cnt_q        <= '0;
         bit_idx_q    <= '0;
         abort_pend_q <= 1'b0;
         tx_q         <= 1'b1;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         snap_q       <= snap_d;
         char_q       <= char_d;
         ind_q        <= ind_d;
         last_q       <= last_d;
         shift_q      <= shift_d;
         cnt_q        <= cnt_d;
         bit_idx_q    <= bit_idx_d;
         abort_pend_q <= abort_pend_d;
         tx_q         <= tx_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      snap_d       = snap_q;
      char_d       = char_q;
      ind_d        = ind_q;
      last_d       = last_q;
      shift_d      = shift_q;
      cnt_d        = cnt_q;
      bit_idx_d    = bit_idx_q;
      abort_pend_d = abort_pend_q;

      if (abort_i && state_q != S_IDLE && state_q != S_DONE) begin
         abort_pend_d = 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (start_i) begin
               snap_d       = sel_population_i[GENE_BITS*POP_SIZE-1 -: C_SNAP_BITS];
               char_d       = '0;
               ind_d        = '0;
               abort_pend_d = 1'b0;
               state_d      = S_FETCH;
            end
         end
         S_FETCH: begin
            shift_d = w_byte;
            last_d  = w_char_last && w_ind_last;
            cnt_d   = '0;
            if (w_char_last) begin
               char_d = '0;
               ind_d  = ind_q + C_IND_W'(1);
            end else begin
               char_d = char_q + C_CHAR_W'(1);
            end
            state_d = S_START;
         end
         S_START: begin
            if (w_bit_end) begin
               cnt_d     = '0;
               bit_idx_d = '0;
               state_d   = S_DATA;
            end else begin
               cnt_d = cnt_q + C_CNT_W'(1);
            end
         end
         S_DATA: begin
            if (w_bit_end) begin
               cnt_d   = '0;
               shift_d = {1'b0, shift_q[7:1]};
               if (bit_idx_q == 3'd7) begin
                  state_d = S_STOP;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q + C_CNT_W'(1);
            end
         end
         S_STOP: begin
            if (w_bit_end) begin
               cnt_d   = '0;
               state_d = (last_q || abort_pend_q) ? S_DONE : S_FETCH;
            end else begin
               cnt_d = cnt_q + C_CNT_W'(1);
            end
         end
         S_DONE: begin
            abort_pend_d = 1'b0;
            state_d      = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // The line level is registered, so it trails the state by one cycle;
      // done and busy are timed to match the line rather than the state.
      case (state_q)
         S_START: tx_d = 1'b0;
         S_DATA:  tx_d = shift_q[0];
         default: tx_d = 1'b1;
      endcase
      done_d = (state_q == S_DONE);
      busy_d = (state_d != S_IDLE) || (state_q == S_DONE);
   end

   assign tx_o   = tx_q;
   assign busy_o = busy_q;
   assign done_o = done_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_population_reporter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_population_reporter
//  Purpose  : Self-checking bench for uart_population_reporter. Drives
//             directed report vectors from a table and decodes the UART line.
//  Ports    : none
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_population_reporter;

   localparam int CPB = 4;

   logic        clk    = 1'b0;
   logic        rst_n  = 1'b0;
   logic [31:0] pop1   = '0;
   logic        start1 = 1'b0;
   logic        abort1 = 1'b0;
   logic        tx1, busy1, done1;
   logic [23:0] pop2   = '0;
   logic        start2 = 1'b0;
   logic        abort2 = 1'b0;
   logic        tx2, busy2, done2;

   int checks    = 0;
   int failures  = 0;
   int busy_tot1 = 0;
   int done_tot1 = 0;
   int busy_tot2 = 0;
   int done_tot2 = 0;

   uart_population_reporter #(
      .GENE_BITS(8), .POP_SIZE(4), .NUM_REPORT(2), .CLKS_PER_BIT(CPB)
   ) u_dut1 (
      .clk_i(clk), .rst_ni(rst_n), .sel_population_i(pop1),
      .start_i(start1), .abort_i(abort1),
      .tx_o(tx1), .busy_o(busy1), .done_o(done1)
   );

   uart_population_reporter #(
      .GENE_BITS(6), .POP_SIZE(4), .NUM_REPORT(1), .CLKS_PER_BIT(CPB)
   ) u_dut2 (
      .clk_i(clk), .rst_ni(rst_n), .sel_population_i(pop2),
      .start_i(start2), .abort_i(abort2),
      .tx_o(tx2), .busy_o(busy2), .done_o(done2)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (busy1 === 1'b1) busy_tot1++;
      if (done1 === 1'b1) done_tot1++;
      if (busy2 === 1'b1) busy_tot2++;
      if (done2 === 1'b1) done_tot2++;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   function automatic logic tx_of(input int sel);
      return (sel == 1) ? tx1 : tx2;
   endfunction
   function automatic logic busy_of(input int sel);
      return (sel == 1) ? busy1 : busy2;
   endfunction
   function automatic logic done_of(input int sel);
      return (sel == 1) ? done1 : done2;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Waits for a start bit, then samples each bit in its middle. abort1 and
   // start1 are pulsed for one cycle at the given offsets into the character.
   task automatic recv_byte(input int sel, input int abort_rel, input int start_rel,
                            output logic [7:0] b, output bit ok, output int waited);
      logic [9:0] bits;
      int n;
      bits = '0;
      n    = 0;
      b    = 8'h00;
      ok   = 1'b0;
      @(negedge clk);
      while (tx_of(sel) !== 1'b0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      waited = n;
      if (n >= 200) return;
      for (int rel = 0; rel < 10*CPB; rel++) begin
         if (rel > 0) @(negedge clk);
         abort1 = (rel == abort_rel);
         start1 = (rel == start_rel);
         if (rel % CPB == CPB/2) bits[rel/CPB] = tx_of(sel);
      end
      @(posedge clk);
      #1;
      abort1 = 1'b0;
      start1 = 1'b0;
      b  = bits[8:1];
      ok = (bits[0] == 1'b0) && (bits[9] == 1'b1);
   endtask

   task automatic run_frame(input int sel, input logic [31:0] pop, input logic [63:0] exp,
                            input int nexp, input int ab_byte, input int ab_rel,
                            input int st_byte, input int st_rel, input bit flip,
                            input bit abort_with_start, input string tag);
      int b0, d0, waited, lows;
      logic [7:0] b;
      bit ok;
      @(negedge clk);
      if (sel == 1) begin
         pop1   = pop;
         start1 = 1'b1;
         abort1 = abort_with_start;
      end else begin
         pop2   = pop[31:8];
         start2 = 1'b1;
      end
      b0 = (sel == 1) ? busy_tot1 : busy_tot2;
      d0 = (sel == 1) ? done_tot1 : done_tot2;
      @(posedge clk);
      #1;
      start1 = 1'b0;
      start2 = 1'b0;
      abort1 = 1'b0;
      @(negedge clk);
      check($sformatf("%s busy_on_accept", tag), 64'(busy_of(sel)), 64'd1);
      check($sformatf("%s tx_high_cycle1", tag), 64'(tx_of(sel)), 64'd1);
      if (flip) pop1 = 32'hFFFF_FFFF;
      @(negedge clk);
      check($sformatf("%s tx_high_cycle2", tag), 64'(tx_of(sel)), 64'd1);
      for (int i = 0; i < nexp; i++) begin
         recv_byte(sel, (i == ab_byte) ? ab_rel : -1, (i == st_byte) ? st_rel : -1,
                   b, ok, waited);
         if (i == 0) check($sformatf("%s start_latency", tag), 64'(waited), 64'd0);
         check($sformatf("%s byte%0d", tag, i), {55'd0, ok, b}, {55'd0, 1'b1, exp[63-8*i -: 8]});
      end
      check($sformatf("%s done_after_stop", tag), 64'(done_of(sel)), 64'd1);
      @(posedge clk);
      #1;
      check($sformatf("%s done_one_cycle", tag), 64'(done_of(sel)), 64'd0);
      check($sformatf("%s busy_dropped", tag), 64'(busy_of(sel)), 64'd0);
      lows = 0;
      repeat (60) begin
         @(negedge clk);
         if (tx_of(sel) !== 1'b1) lows++;
      end
      check($sformatf("%s line_quiet", tag), 64'(lows), 64'd0);
      check($sformatf("%s busy_cycles", tag),
            64'(((sel == 1) ? busy_tot1 : busy_tot2) - b0), 64'(nexp*(10*CPB+1)+2));
      check($sformatf("%s done_pulses", tag),
            64'(((sel == 1) ? done_tot1 : done_tot2) - d0), 64'd1);
   endtask

   typedef struct {
      logic [31:0] pop;
      logic [63:0] exp;
      int          nexp;
      int          ab_byte;
      int          ab_rel;
      int          st_byte;
      int          st_rel;
      bit          flip;
      bit          abort_start;
   } vec_t;

   vec_t vecs[9];

   initial begin
      logic [7:0] b;
      bit ok;
      int waited, n;
      logic [63:0] frame_a;
      frame_a = 64'h4135_0D0A_3343_0D0A;

      vecs[0] = '{32'hA53C_00FF, frame_a,                8, -1, -1, -1, -1, 1'b0, 1'b0};
      vecs[1] = '{32'h00FF_1234, 64'h3030_0D0A_4646_0D0A, 8, -1, -1, -1, -1, 1'b0, 1'b0};
      vecs[2] = '{32'h129B_AA55, 64'h3132_0D0A_3942_0D0A, 8, -1, -1, -1, -1, 1'b0, 1'b0};
      vecs[3] = '{32'h7EC8_0000, 64'h3745_0D0A_4338_0D0A, 8, -1, -1, -1, -1, 1'b0, 1'b0};
      // snapshot isolation: population changes one cycle after start
      vecs[4] = '{32'hA53C_00FF, frame_a,                8, -1, -1, -1, -1, 1'b1, 1'b0};
      // abort in the 3rd data bit of the second character (0x35)
      vecs[5] = '{32'hA53C_00FF, 64'h4135_0000_0000_0000, 2, 1, 13, -1, -1, 1'b0, 1'b0};
      // start while busy, mid-report
      vecs[6] = '{32'hA53C_00FF, frame_a,                8, -1, -1, 3, 5, 1'b0, 1'b0};
      // start during the DONE cycle
      vecs[7] = '{32'hA53C_00FF, frame_a,                8, -1, -1, 7, 39, 1'b0, 1'b0};
      // start and abort together while idle
      vecs[8] = '{32'hA53C_00FF, frame_a,                8, -1, -1, -1, -1, 1'b0, 1'b1};

      // Reset state
      repeat (3) @(negedge clk);
      check("reset tx1", 64'(tx1), 64'd1);
      check("reset busy1", 64'(busy1), 64'd0);
      check("reset done1", 64'(done1), 64'd0);
      check("reset tx2", 64'(tx2), 64'd1);
      rst_n = 1'b1;
      // abort while idle must be ignored
      abort1 = 1'b1;
      @(negedge clk);
      abort1 = 1'b0;
      @(negedge clk);
      check("idle busy1", 64'(busy1), 64'd0);
      check("idle tx1", 64'(tx1), 64'd1);

      for (int v = 0; v < 9; v++) begin
         run_frame(1, vecs[v].pop, vecs[v].exp, vecs[v].nexp, vecs[v].ab_byte, vecs[v].ab_rel,
                   vecs[v].st_byte, vecs[v].st_rel, vecs[v].flip, vecs[v].abort_start,
                   $sformatf("vec%0d", v));
      end

      // Left zero-padding: 6-bit individual 101101 -> "2D"
      run_frame(2, {6'b101101, 18'h0, 8'h0}, 64'h3244_0D0A_0000_0000, 4, -1, -1, -1, -1,
                1'b0, 1'b0, "pad");

      // Start in the first idle cycle after DONE launches a new report
      @(negedge clk);
      pop1   = 32'hA53C_00FF;
      start1 = 1'b1;
      @(posedge clk);
      #1;
      start1 = 1'b0;
      for (int i = 0; i < 8; i++) begin
         recv_byte(1, -1, -1, b, ok, waited);
         check($sformatf("chainA byte%0d", i), {55'd0, ok, b}, {55'd0, 1'b1, frame_a[63-8*i -: 8]});
      end
      check("chainA done", 64'(done1), 64'd1);
      pop1   = 32'h129B_AA55;
      start1 = 1'b1;
      @(posedge clk);
      #1;
      start1 = 1'b0;
      check("chainB restart_busy", 64'(busy1), 64'd1);
      for (int i = 0; i < 8; i++) begin
         recv_byte(1, -1, -1, b, ok, waited);
         check($sformatf("chainB byte%0d", i), {55'd0, ok, b},
               {55'd0, 1'b1, vecs[2].exp[63-8*i -: 8]});
      end
      check("chainB done", 64'(done1), 64'd1);
      @(posedge clk);
      #1;
      check("chainB busy_dropped", 64'(busy1), 64'd0);

      // Asynchronous reset in the middle of a data bit that is 0
      repeat (5) @(negedge clk);
      pop1   = 32'hA53C_00FF;
      start1 = 1'b1;
      @(posedge clk);
      #1;
      start1 = 1'b0;
      n = 0;
      @(negedge clk);
      while (tx1 !== 1'b0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("rst start_seen", 64'(n < 200), 64'd1);
      repeat (9) @(negedge clk);
      check("rst data_bit1_low", 64'(tx1), 64'd0);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst tx_high", 64'(tx1), 64'd1);
      check("rst busy_low", 64'(busy1), 64'd0);
      check("rst done_low", 64'(done1), 64'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      run_frame(1, vecs[0].pop, vecs[0].exp, 8, -1, -1, -1, -1, 1'b0, 1'b0, "post_reset");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
